// File: rtl/queue_nm_pkg.sv
// Shared defaults and helpers for the queue_nm block and its lshfn_fixed leaf.
package queue_nm_pkg;
  localparam int DEF_M_WIDTH  = 16;
  localparam int DEF_N_WIDTH  = 16;
  localparam int DEF_Q_LENGTH = 16;
  localparam int DEF_SHF_AMNT = 2;

  // The count has to represent every value from 0 through depth inclusive.
  function automatic int cnt_width(int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/lshfn_fixed.sv
// Fixed-distance left shifter. Integrators use it to build per-entry M updates.
module lshfn_fixed
  import queue_nm_pkg::*;
#(
  parameter int WIDTH    = DEF_M_WIDTH,
  parameter int SHF_AMNT = DEF_SHF_AMNT
) (
  input  logic [WIDTH-1:0]    in,
  input  logic [SHF_AMNT-1:0] shf_val,
  output logic [WIDTH-1:0]    out
);
  // The top SHF_AMNT bits of in are dropped by the truncating cast.
  assign out = WIDTH'({in, shf_val});
endmodule

// File: rtl/queue_nm.sv
// FIFO of {M, N} entries. Every occupied M field is exposed and can be rewritten in place.
// Storage is a shift register, so position 0 always holds the head.
module queue_nm
  import queue_nm_pkg::*;
#(
  parameter int M_WIDTH  = DEF_M_WIDTH,
  parameter int N_WIDTH  = DEF_N_WIDTH,
  parameter int Q_LENGTH = DEF_Q_LENGTH
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [M_WIDTH-1:0]           m_din,
  input  logic [N_WIDTH-1:0]           n_din,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [Q_LENGTH-1:0]          modify_vector,
  input  logic [M_WIDTH*Q_LENGTH-1:0]  new_m_vector,
  output logic [M_WIDTH*Q_LENGTH-1:0]  old_m_vector,
  output logic [M_WIDTH+N_WIDTH-1:0]   dout,
  output logic                         full,
  output logic                         empty
);
  localparam int CW = cnt_width(Q_LENGTH);

  logic [CW-1:0]      count_q, count_d, tail;
  logic               pop, push;
  logic [M_WIDTH-1:0] m_q [Q_LENGTH];
  logic [M_WIDTH-1:0] m_d [Q_LENGTH];
  logic [M_WIDTH-1:0] upd_m [Q_LENGTH];
  logic [N_WIDTH-1:0] n_q [Q_LENGTH];
  logic [N_WIDTH-1:0] n_d [Q_LENGTH];

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(Q_LENGTH));
  assign pop     = rd && !empty;
  assign push    = wr && !full;
  assign tail    = count_q - CW'(pop);
  assign count_d = tail + CW'(push);

  assign dout = empty ? '0 : {m_q[0], n_q[0]};

  genvar g;
  for (g = 0; g < Q_LENGTH; g++) begin : g_entry
    logic valid;
    assign valid = (count_q > CW'(g));
    assign upd_m[g] = (valid && modify_vector[g]) ? new_m_vector[g*M_WIDTH +: M_WIDTH] : m_q[g];
    assign old_m_vector[g*M_WIDTH +: M_WIDTH] = valid ? m_q[g] : '0;
  end

  // Modified values move down with the pop; the popped head's update is simply dropped.
  for (g = 0; g < Q_LENGTH; g++) begin : g_next
    logic [M_WIDTH-1:0] shf_m;
    logic [N_WIDTH-1:0] shf_n;
    if (g < Q_LENGTH - 1) begin : g_mid
      assign shf_m = pop ? upd_m[g+1] : upd_m[g];
      assign shf_n = pop ? n_q[g+1]   : n_q[g];
    end else begin : g_last
      assign shf_m = upd_m[g];
      assign shf_n = n_q[g];
    end
    assign m_d[g] = (push && tail == CW'(g)) ? m_din : shf_m;
    assign n_d[g] = (push && tail == CW'(g)) ? n_din : shf_n;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) count_q <= '0;
    else      count_q <= count_d;
  end

  // Payload needs no reset: every output masks positions at or beyond count_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Q_LENGTH; i++) begin
      m_q[i] <= m_d[i];
      n_q[i] <= n_d[i];
    end
  end
endmodule

// File: tb/tb_queue_nm.sv
// Bench for queue_nm: directed scenarios plus random traffic against a queue-based reference.
module tb_queue_nm;
  logic         clk = 1'b0;
  logic         clr;
  logic [15:0]  m_din, n_din;
  logic         wr, rd;
  logic [15:0]  modify_vector;
  logic [255:0] new_m_vector, old_m_vector, shf_vec, rnd_vec;
  logic         use_shf;
  logic [31:0]  dout;
  logic         full, empty;
  logic [15:0]  lt_in, lt_out;
  logic [1:0]   lt_shf;

  int checks = 0;
  int passes = 0;
  logic [31:0] model_q[$];

  always #5 clk = ~clk;

  queue_nm #(.M_WIDTH(16), .N_WIDTH(16), .Q_LENGTH(16)) dut (
    .clk(clk), .clr(clr), .m_din(m_din), .n_din(n_din), .wr(wr), .rd(rd),
    .modify_vector(modify_vector), .new_m_vector(new_m_vector),
    .old_m_vector(old_m_vector), .dout(dout), .full(full), .empty(empty)
  );

  for (genvar g = 0; g < 16; g++) begin : g_shf
    lshfn_fixed #(.WIDTH(16), .SHF_AMNT(2)) u_shf (
      .in(old_m_vector[g*16 +: 16]), .shf_val(2'b00), .out(shf_vec[g*16 +: 16])
    );
  end

  lshfn_fixed #(.WIDTH(16), .SHF_AMNT(2)) u_lsh_t (.in(lt_in), .shf_val(lt_shf), .out(lt_out));

  assign new_m_vector = use_shf ? shf_vec : rnd_vec;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string ctx);
    logic [255:0] exp_old;
    logic [31:0]  exp_dout;
    exp_old  = '0;
    exp_dout = (model_q.size() > 0) ? model_q[0] : 32'h0;
    for (int i = 0; i < model_q.size(); i++) exp_old[i*16 +: 16] = model_q[i][31:16];
    check({ctx, ".dout"},  256'(dout), 256'(exp_dout));
    check({ctx, ".old_m"}, old_m_vector, exp_old);
    check({ctx, ".empty"}, 256'(empty), 256'(model_q.size() == 0));
    check({ctx, ".full"},  256'(full),  256'(model_q.size() == 16));
  endtask

  task automatic model_step(input logic w, input logic r, input logic [15:0] mod, input logic s,
                            input logic [15:0] md, input logic [15:0] nd);
    int  sz;
    bit  do_pop, do_push;
    logic [15:0] mm;
    sz      = model_q.size();
    do_pop  = r && sz > 0;
    do_push = w && sz < 16;
    for (int i = 0; i < sz; i++) begin
      if (mod[i]) begin
        mm = model_q[i][31:16];
        mm = s ? (mm << 2) : rnd_vec[i*16 +: 16];
        model_q[i][31:16] = mm;
      end
    end
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back({md, nd});
  endtask

  task automatic do_cycle(input string ctx, input logic w, input logic r, input logic [15:0] mod,
                          input logic s, input logic [15:0] md, input logic [15:0] nd);
    wr = w; rd = r; modify_vector = mod; use_shf = s; m_din = md; n_din = nd;
    #1;
    check_outputs(ctx);
    model_step(w, r, mod, s, md, nd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b0; wr = 1'b0; rd = 1'b0; modify_vector = '0; use_shf = 1'b1;
    m_din = '0; n_din = '0; rnd_vec = '0; lt_in = '0; lt_shf = '0;
    #2;
    check_outputs("reset");
    @(negedge clk);
    clr = 1'b1;

    for (int k = 0; k < 9; k++) do_cycle("fill", 1'b1, 1'b0, 16'h0, 1'b1, 16'hFFFF, 16'(k * 16'h1111));
    for (int k = 0; k < 12; k++) begin
      if (k < 9) begin
        logic [15:0] em;
        em = 16'hFFFF;
        em = em << (2 * k);
        check("drain.seq", 256'(dout), 256'({em, 16'(k * 16'h1111)}));
      end
      do_cycle("drain", 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0, 16'h0);
    end

    for (int k = 9; k < 16; k++) do_cycle("wrap.push", 1'b1, 1'b0, 16'h0, 1'b1, 16'hFFFF, 16'(k * 16'h1111));
    for (int k = 0; k < 8; k++) do_cycle("wrap.pop", 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0, 16'h0);

    for (int k = 0; k < 17; k++) do_cycle("full", 1'b1, 1'b0, 16'h0, 1'b1, 16'(16'hA000 + k), 16'(k));
    do_cycle("full.wr_rd", 1'b1, 1'b1, 16'h0, 1'b1, 16'hBEEF, 16'hBEEF);
    for (int k = 0; k < 10; k++) do_cycle("to5", 1'b0, 1'b1, 16'h0, 1'b1, 16'h0, 16'h0);
    do_cycle("conc", 1'b1, 1'b1, 16'h0010, 1'b1, 16'h1234, 16'h5678);
    check("conc.count", 256'(model_q.size()), 256'(5));
    do_cycle("conc.after", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0, 16'h0);

    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 8; k++) rnd_vec[k*32 +: 32] = $urandom;
      do_cycle("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
               16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end

    clr = 1'b0;
    model_q.delete();
    #1;
    check_outputs("midreset");
    clr = 1'b1;
    do_cycle("post_reset", 1'b1, 1'b0, 16'h0, 1'b1, 16'hCAFE, 16'hF00D);
    do_cycle("post_reset.chk", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0, 16'h0);

    lt_in = 16'h8001; lt_shf = 2'b11;
    #1;
    check("lshfn.8001", 256'(lt_out), 256'(16'h0007));
    for (int k = 0; k < 6; k++) begin
      logic [17:0] wide;
      lt_in = 16'($urandom); lt_shf = 2'($urandom);
      #1;
      wide = ({2'b00, lt_in} * 4) + 18'(lt_shf);
      check("lshfn.rand", 256'(lt_out), 256'(wide[15:0]));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
